// File: rtl/cpu_bus_if_if.sv
// rtl/cpu_bus_if_if.sv - CPU bus and BRAM port bundle for the cpu_bus_if bridge
interface cpu_bus_if_if #(
  parameter int STM_SEG_W = 5
);
  // CPU bus side
  logic                    en;
  logic                    we;
  logic [1:0]              bram_select;
  logic [13:0]             bram_addr;
  logic [15:0]             data_in;
  logic [15:0]             data_out;
  // BRAM side
  logic                    ctl_we;
  logic                    normal_we;
  logic                    mod_we;
  logic                    stm_we;
  logic [13:0]             ctl_addr;
  logic [13:0]             normal_addr;
  logic [14:0]             mod_addr;
  logic [13+STM_SEG_W:0]   stm_addr;
  logic [15:0]             wdata;
  logic [13:0]             ctl_raddr;
  logic [15:0]             ctl_rdata;
  logic                    mod_segment;
  logic [15:0]             stm_segment;

  modport slave (
    input  en, we, bram_select, bram_addr, data_in, ctl_rdata,
    output data_out, ctl_we, normal_we, mod_we, stm_we,
           ctl_addr, normal_addr, mod_addr, stm_addr, wdata,
           ctl_raddr, mod_segment, stm_segment
  );

  modport master (
    output en, we, bram_select, bram_addr, data_in, ctl_rdata,
    input  data_out, ctl_we, normal_we, mod_we, stm_we,
           ctl_addr, normal_addr, mod_addr, stm_addr, wdata,
           ctl_raddr, mod_segment, stm_segment
  );
endinterface

// File: rtl/cpu_bus_if.sv
// rtl/cpu_bus_if.sv - CPU external bus to BRAM bridge with segment extension and read-back
module cpu_bus_if #(
  parameter logic [1:0]  SEL_CONTROLLER       = 2'd0,
  parameter logic [1:0]  SEL_MOD              = 2'd1,
  parameter logic [1:0]  SEL_NORMAL           = 2'd2,
  parameter logic [1:0]  SEL_STM              = 2'd3,
  parameter logic [13:0] ADDR_MOD_MEM_SEGMENT = 14'h020,
  parameter logic [13:0] ADDR_STM_MEM_SEGMENT = 14'h050,
  parameter int          STM_SEG_W            = 5
) (
  input logic           bus_clk,
  input logic           rst,
  cpu_bus_if_if.slave   bus
);

  logic                  en_q;
  logic                  we_q;
  logic                  we_d;
  logic [1:0]            sel_q;
  logic [13:0]           addr_q;
  logic [15:0]           data_q;
  logic                  write_det;

  logic                  ctl_we;
  logic                  normal_we;
  logic                  mod_we;
  logic                  stm_we;
  logic [13:0]           ctl_addr;
  logic [13:0]           normal_addr;
  logic [14:0]           mod_addr;
  logic [13+STM_SEG_W:0] stm_addr;
  logic [15:0]           wdata;
  logic [15:0]           data_out;
  logic                  mod_segment;
  logic [15:0]           stm_segment;

  // Rising edge of WE while selected; we_d clears on reset so the first
  // post-reset edge is measured against a known low.
  assign write_det = en_q & we_q & ~we_d;

  // Register the asynchronous-timing CPU bus inputs once on the bus clock.
  always_ff @(posedge bus_clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      we_d   <= 1'b0;
      sel_q  <= 2'd0;
      addr_q <= 14'd0;
      data_q <= 16'd0;
    end else begin
      en_q   <= bus.en;
      we_q   <= bus.we;
      we_d   <= we_q;
      sel_q  <= bus.bram_select;
      addr_q <= bus.bram_addr;
      data_q <= bus.data_in;
    end
  end

  // Decode an accepted write into one-cycle strobes, latched address/data
  // and segment updates; segments change at the strobe edge so the address
  // registered in the same edge still carries the previous segment.
  always_ff @(posedge bus_clk) begin
    if (rst) begin
      ctl_we      <= 1'b0;
      normal_we   <= 1'b0;
      mod_we      <= 1'b0;
      stm_we      <= 1'b0;
      ctl_addr    <= 14'd0;
      normal_addr <= 14'd0;
      mod_addr    <= 15'd0;
      stm_addr    <= '0;
      wdata       <= 16'd0;
      mod_segment <= 1'b0;
      stm_segment <= 16'd0;
    end else begin
      ctl_we    <= write_det && (sel_q == SEL_CONTROLLER);
      mod_we    <= write_det && (sel_q == SEL_MOD);
      normal_we <= write_det && (sel_q == SEL_NORMAL);
      stm_we    <= write_det && (sel_q == SEL_STM);
      if (write_det) begin
        ctl_addr    <= addr_q;
        normal_addr <= addr_q;
        mod_addr    <= {mod_segment, addr_q};
        stm_addr    <= {stm_segment[STM_SEG_W-1:0], addr_q};
        wdata       <= data_q;
      end
      if (write_det && (sel_q == SEL_CONTROLLER) && (addr_q == ADDR_MOD_MEM_SEGMENT)) begin
        mod_segment <= data_q[0];
      end
      if (write_det && (sel_q == SEL_CONTROLLER) && (addr_q == ADDR_STM_MEM_SEGMENT)) begin
        stm_segment <= data_q;
      end
    end
  end

  // Capture controller BRAM read data while a controller read is on the bus;
  // otherwise hold the last value for the CPU.
  always_ff @(posedge bus_clk) begin
    if (rst) begin
      data_out <= 16'd0;
    end else if (en_q && !we_q && (sel_q == SEL_CONTROLLER)) begin
      data_out <= bus.ctl_rdata;
    end
  end

  assign bus.ctl_raddr   = addr_q;
  assign bus.ctl_we      = ctl_we;
  assign bus.normal_we   = normal_we;
  assign bus.mod_we      = mod_we;
  assign bus.stm_we      = stm_we;
  assign bus.ctl_addr    = ctl_addr;
  assign bus.normal_addr = normal_addr;
  assign bus.mod_addr    = mod_addr;
  assign bus.stm_addr    = stm_addr;
  assign bus.wdata       = wdata;
  assign bus.data_out    = data_out;
  assign bus.mod_segment = mod_segment;
  assign bus.stm_segment = stm_segment;

endmodule

// File: tb/tb_cpu_bus_if.sv
// tb/tb_cpu_bus_if.sv - self-checking bench for cpu_bus_if with reference model
module tb_cpu_bus_if;
  localparam int SW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_bus_if_if #(.STM_SEG_W(SW)) bus ();
  cpu_bus_if #(.STM_SEG_W(SW)) u_dut (.bus_clk(clk), .rst(rst), .bus(bus));

  logic [15:0] bram    [16384];
  logic [15:0] ref_ctl [16384];
  int n_assert = 0;
  int n_fail = 0;
  int ref_mod_seg = 0;
  int ref_stm_seg = 0;
  int normal_cnt = 0;

  // controller BRAM with one cycle read latency, plus a strobe counter
  always @(posedge clk) begin
    if (bus.ctl_we === 1'b1) bram[bus.ctl_addr] <= bus.wdata;
    bus.ctl_rdata <= bram[bus.ctl_raddr];
    if (bus.normal_we === 1'b1) normal_cnt <= normal_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, bus.ctl_we, bus.mod_we, bus.normal_we, bus.stm_we};
  endfunction

  task automatic do_write(input logic [1:0] s, input logic [13:0] a, input logic [15:0] d, input int hi);
    int exp_addr;
    logic [3:0] vec;
    case (s)
      2'd0: begin vec = 4'b1000; exp_addr = int'(a); end
      2'd1: begin vec = 4'b0100; exp_addr = ref_mod_seg * 16384 + int'(a); end
      2'd2: begin vec = 4'b0010; exp_addr = int'(a); end
      default: begin vec = 4'b0001; exp_addr = (ref_stm_seg % 32) * 16384 + int'(a); end
    endcase
    bus.en = 1'b1; bus.we = 1'b1; bus.bram_select = s; bus.bram_addr = a; bus.data_in = d;
    for (int i = 0; i < hi; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        chk("strobe", strobes(), {28'd0, vec});
        case (s)
          2'd0: chk("ctl_addr", {18'd0, bus.ctl_addr}, exp_addr);
          2'd1: chk("mod_addr", {17'd0, bus.mod_addr}, exp_addr);
          2'd2: chk("normal_addr", {18'd0, bus.normal_addr}, exp_addr);
          default: chk("stm_addr", {13'd0, bus.stm_addr}, exp_addr);
        endcase
        chk("wdata", {16'd0, bus.wdata}, {16'd0, d});
        if (s == 2'd0) begin
          ref_ctl[a] = d;
          if (a == 14'h020) ref_mod_seg = int'(d[0]);
          if (a == 14'h050) ref_stm_seg = int'(d);
        end
        chk("mod_segment", {31'd0, bus.mod_segment}, ref_mod_seg);
        chk("stm_segment", {16'd0, bus.stm_segment}, ref_stm_seg);
      end else begin
        chk("no_strobe_hold", strobes(), 0);
      end
    end
    bus.we = 1'b0; bus.en = 1'b0;
    @(posedge clk); #1;
    chk("no_strobe_after", strobes(), 0);
  endtask

  task automatic do_read(input logic [13:0] a);
    bus.en = 1'b1; bus.we = 1'b0; bus.bram_select = 2'd0; bus.bram_addr = a;
    repeat (3) @(posedge clk);
    #1;
    chk("read_data", {16'd0, bus.data_out}, {16'd0, ref_ctl[a]});
    bus.en = 1'b0;
  endtask

  initial begin
    int c0;
    logic [1:0] s;
    logic [13:0] a;
    for (int i = 0; i < 16384; i++) begin bram[i] = 16'd0; ref_ctl[i] = 16'd0; end
    bus.en = 1'b0; bus.we = 1'b0; bus.bram_select = 2'd0; bus.bram_addr = 14'd0; bus.data_in = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", strobes(), 0);
    chk("rst_data_out", {16'd0, bus.data_out}, 0);
    chk("rst_mod_seg", {31'd0, bus.mod_segment}, 0);
    chk("rst_stm_seg", {16'd0, bus.stm_segment}, 0);
    chk("rst_wdata", {16'd0, bus.wdata}, 0);
    chk("rst_mod_addr", {17'd0, bus.mod_addr}, 0);
    chk("rst_stm_addr", {13'd0, bus.stm_addr}, 0);
    rst = 1'b0;

    do_write(2'd0, 14'h021, 16'h1234, 2);
    do_write(2'd0, 14'h020, 16'h0001, 2);
    do_write(2'd1, 14'h0005, 16'hBEEF, 3);
    chk("tp_mod_addr", {17'd0, bus.mod_addr}, 32'h4005);
    chk("tp_mod_seg", {31'd0, bus.mod_segment}, 1);
    do_write(2'd0, 14'h050, 16'h0003, 2);
    do_write(2'd3, 14'h0200, 16'($urandom), 2);
    chk("tp_stm_addr", {13'd0, bus.stm_addr}, {13'd0, 5'd3, 14'h0200});
    chk("tp_stm_seg", {16'd0, bus.stm_segment}, 3);

    do_read(14'h021);
    chk("tp_read_1234", {16'd0, bus.data_out}, 32'h1234);
    do_write(2'd2, 14'd7, 16'($urandom), 2);
    chk("read_hold", {16'd0, bus.data_out}, 32'h1234);

    bus.en = 1'b0; bus.we = 1'b1; bus.bram_select = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("en_low_ignored", strobes(), 0);
    end
    bus.we = 1'b0;
    @(posedge clk); #1;

    c0 = normal_cnt;
    for (int p = 0; p < 249; p++) begin
      do_write(2'd2, 14'(2 * p), 16'($urandom), int'($urandom_range(2, 4)));
      do_write(2'd2, 14'(2 * p + 1), 16'($urandom), int'($urandom_range(2, 4)));
    end
    chk("normal_sweep_count", normal_cnt - c0, 498);

    bus.en = 1'b1; bus.we = 1'b1; bus.bram_select = 2'd1; bus.bram_addr = 14'd9; bus.data_in = 16'hA5A5;
    @(posedge clk); #1;
    rst = 1'b1; bus.we = 1'b0; bus.en = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_strobe", strobes(), 0);
    chk("rst_mid_mod_seg", {31'd0, bus.mod_segment}, 0);
    chk("rst_mid_stm_seg", {16'd0, bus.stm_segment}, 0);
    rst = 1'b0; ref_mod_seg = 0; ref_stm_seg = 0;
    @(posedge clk); #1;
    chk("rst_after_strobe", strobes(), 0);
    do_write(2'd1, 14'h0005, 16'h55AA, 2);
    chk("post_rst_mod_addr", {17'd0, bus.mod_addr}, 32'h0005);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_read(14'($urandom_range(0, 95)));
      end else begin
        s = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
          0: a = 14'h020;
          1: a = 14'h050;
          2: a = 14'($urandom_range(0, 95));
          default: a = 14'($urandom);
        endcase
        do_write(s, a, 16'($urandom), int'($urandom_range(2, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
